// File: rtl/mem_port_arbiter_pkg.sv
// Shared core constants for the fetch/data memory port arbiter:
// arbiter state encoding and the layout of the write-enable/size field.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_t;

    // Access-control field: one write-enable bit plus a two-bit size code.
    localparam int unsigned WE_BIT   = 2;
    localparam int unsigned SIZE_LSB = 0;
    localparam int unsigned SIZE_W   = 2;

    function automatic logic is_store(input logic [2:0] we);
        return we[WE_BIT];
    endfunction

    // Rebuilds the port control field from its named parts so the layout
    // lives in exactly one place.
    function automatic logic [2:0] port_we(input logic [2:0] we);
        logic [2:0] r;
        r = '0;
        r[WE_BIT] = we[WE_BIT];
        r[SIZE_LSB +: SIZE_W] = we[SIZE_LSB +: SIZE_W];
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data
// access: data wins by default, fetch is guaranteed a grant after STARVE_MAX.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_stall,
    input  logic            ma_req,
    input  logic [2:0]      ma_we,
    input  logic [XLEN-1:0] ma_addr,
    input  logic [XLEN-1:0] ma_wdata,
    output logic [XLEN-1:0] ma_rdata,
    output logic            ma_stall,
    output logic            mem_req,
    output logic [2:0]      mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve;
    logic             grant_d;
    logic             grant_i;
    logic             store_q;

    assign starve  = if_req && (starve_cnt == CNT_MAX);
    assign grant_d = (state == IDLE) && ma_req && !starve;
    assign grant_i = (state == IDLE) && !grant_d && if_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I:  if (mem_ready) state_nxt = DONE_I;
            BUSY_D:  if (mem_ready) state_nxt = DONE_D;
            DONE_I:  state_nxt = IDLE;
            DONE_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 3'b000;
        mem_addr  = if_addr;
        mem_wdata = '0;
        case (state)
            BUSY_I: begin
                mem_req = 1'b1;
            end
            BUSY_D: begin
                mem_req   = 1'b1;
                mem_we    = port_we(ma_we);
                mem_addr  = ma_addr;
                mem_wdata = ma_wdata;
            end
            default: ;
        endcase
        if_stall = if_req && (state != DONE_I);
        ma_stall = ma_req && (state != DONE_D);
    end

    // The starvation count only means something while fetch is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Load/store kind is captured at grant so a requester that drops its
    // request mid-transaction cannot change how the completion is handled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
        end else if (grant_d) begin
            store_q <= is_store(ma_we);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            ma_rdata <= '0;
        end else if (mem_ready) begin
            if (state == BUSY_I) begin
                if_rdata <= mem_rdata;
            end
            if ((state == BUSY_D) && !store_q) begin
                ma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

    localparam int XLEN       = 64;
    localparam int STARVE_MAX = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            if_req = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic [XLEN-1:0] if_rdata;
    logic            if_stall;
    logic            ma_req = 1'b0;
    logic [2:0]      ma_we = 3'b000;
    logic [XLEN-1:0] ma_addr = '0;
    logic [XLEN-1:0] ma_wdata = '0;
    logic [XLEN-1:0] ma_rdata;
    logic            ma_stall;
    logic            mem_req;
    logic [2:0]      mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready = 1'b0;
    logic [XLEN-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata), .ma_stall(ma_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] rd_fn(input logic [XLEN-1:0] a);
        if (a == 64'h100) return 64'h13;
        return (a ^ 64'hC0DE_0000_0000_0000) + 64'h7;
    endfunction

    // Memory responder: read data is a pure function of the address.
    assign mem_rdata = rd_fn(mem_addr);

    int wait_n      = 0;
    bit force_ready = 1'b0;
    int rcnt        = 0;

    always begin
        @(posedge clk);
        #2;
        if (!mem_req) rcnt = 0;
        mem_ready = force_ready || (mem_req && (rcnt == wait_n));
        if (mem_req) rcnt++;
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: who owns the port and where that transaction is.
    // owner 0 none / 1 fetch / 2 data; phase 0 free / 1 on the port / 2 finishing.
    int              owner = 0;
    int              phase = 0;
    int              d_streak = 0;
    bit              m_store = 1'b0;
    logic [XLEN-1:0] exp_if_rdata = '0;
    logic [XLEN-1:0] exp_ma_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= 0;
            phase        <= 0;
            d_streak     <= 0;
            m_store      <= 1'b0;
            exp_if_rdata <= '0;
            exp_ma_rdata <= '0;
        end else begin
            case (phase)
                0: begin
                    if (ma_req && !(if_req && d_streak >= STARVE_MAX)) begin
                        owner    <= 2;
                        phase    <= 1;
                        m_store  <= ma_we[2];
                        d_streak <= !if_req ? 0 : ((d_streak < STARVE_MAX) ? d_streak + 1 : d_streak);
                    end else if (if_req) begin
                        owner    <= 1;
                        phase    <= 1;
                        d_streak <= 0;
                    end else begin
                        d_streak <= 0;
                    end
                end
                1: begin
                    if (!if_req) d_streak <= 0;
                    if (mem_ready) begin
                        phase <= 2;
                        if (owner == 1) exp_if_rdata <= rd_fn(if_addr);
                        else if (!m_store) exp_ma_rdata <= rd_fn(ma_addr);
                    end
                end
                default: begin
                    if (!if_req) d_streak <= 0;
                    phase <= 0;
                    owner <= 0;
                end
            endcase
        end
    end

    logic [XLEN-1:0] grants[$];
    logic            prev_req = 1'b0;

    always @(negedge clk) begin
        chk("mem_req", {63'd0, mem_req}, {63'd0, phase == 1});
        if (phase == 1) begin
            chk("mem_addr", mem_addr, (owner == 2) ? ma_addr : if_addr);
            chk("mem_we", {61'd0, mem_we}, {61'd0, (owner == 2) ? ma_we : 3'b000});
            if (owner == 2) chk("mem_wdata", mem_wdata, ma_wdata);
        end
        chk("if_stall", {63'd0, if_stall}, {63'd0, if_req && !(phase == 2 && owner == 1)});
        chk("ma_stall", {63'd0, ma_stall}, {63'd0, ma_req && !(phase == 2 && owner == 2)});
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("ma_rdata", ma_rdata, exp_ma_rdata);
        if (mem_req && !prev_req) grants.push_back(mem_addr);
        prev_req = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] g(input int i);
        if (grants.size() > i) return grants[i];
        return '1;
    endfunction

    initial begin
        int n;
        bit seen;
        repeat (2) tick();
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_ma_rdata", ma_rdata, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, zero wait states.
        if_req = 1'b1; if_addr = 64'h100; wait_n = 0;
        tick();
        chk("t1_c1_mem_req", {63'd0, mem_req}, 64'd1);
        chk("t1_c1_mem_addr", mem_addr, 64'h100);
        chk("t1_c1_if_stall", {63'd0, if_stall}, 64'd1);
        tick();
        chk("t1_c2_if_stall", {63'd0, if_stall}, 64'd0);
        chk("t1_c2_if_rdata", if_rdata, 64'h13);
        if_req = 1'b0;
        tick();

        // Simultaneous requests: data first, fetch after DONE_D + IDLE.
        if_req = 1'b1; if_addr = 64'h200;
        ma_req = 1'b1; ma_addr = 64'h300; ma_we = 3'b011; ma_wdata = 64'h55;
        tick();
        chk("t2_c1_mem_addr", mem_addr, 64'h300);
        chk("t2_c1_mem_we", {61'd0, mem_we}, 64'd3);
        tick();
        chk("t2_c2_ma_stall", {63'd0, ma_stall}, 64'd0);
        chk("t2_c2_ma_rdata", ma_rdata, rd_fn(64'h300));
        ma_req = 1'b0;
        tick();
        chk("t2_c3_mem_req", {63'd0, mem_req}, 64'd0);
        tick();
        chk("t2_c4_mem_addr", mem_addr, 64'h200);
        chk("t2_c4_mem_req", {63'd0, mem_req}, 64'd1);
        tick();
        chk("t2_c5_if_stall", {63'd0, if_stall}, 64'd0);
        if_req = 1'b0;
        tick();

        // Store with three wait states.
        ma_req = 1'b1; ma_we = 3'b111; ma_addr = 64'h400; ma_wdata = 64'hDEAD; wait_n = 3;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_req && mem_we == 3'b111 && mem_wdata == 64'hDEAD) n++;
        end
        chk("t3_busy_cycles", 64'(n), 64'd4);
        chk("t3_ma_stall", {63'd0, ma_stall}, 64'd0);
        chk("t3_ma_rdata_kept", ma_rdata, rd_fn(64'h300));
        ma_req = 1'b0; wait_n = 0;
        tick();

        // Starvation: data held, fetch waiting.
        grants.delete();
        if_req = 1'b1; if_addr = 64'h500;
        ma_req = 1'b1; ma_addr = 64'h600; ma_we = 3'b010;
        repeat (20) tick();
        chk("t4_ngrants", {63'd0, grants.size() >= 6}, 64'd1);
        for (int i = 0; i < 4; i++) chk("t4_data_grant", g(i), 64'h600);
        chk("t4_fetch_grant5", g(4), 64'h500);
        chk("t4_data_grant6", g(5), 64'h600);
        if_req = 1'b0; ma_req = 1'b0;
        repeat (3) tick();

        // Stray mem_ready while idle.
        force_ready = 1'b1;
        repeat (3) tick();
        chk("t5_mem_req", {63'd0, mem_req}, 64'd0);
        force_ready = 1'b0;
        tick();

        // Fetch dropped mid-transaction.
        if_req = 1'b1; if_addr = 64'h700; wait_n = 2;
        tick();
        if_req = 1'b0;
        tick();
        chk("t6_c2_mem_req", {63'd0, mem_req}, 64'd1);
        tick();
        tick();
        chk("t6_c4_mem_req", {63'd0, mem_req}, 64'd0);
        chk("t6_if_rdata", if_rdata, rd_fn(64'h700));
        tick();
        wait_n = 0;

        // Reset in the middle of a data transaction.
        ma_req = 1'b1; ma_addr = 64'h800; ma_we = 3'b001; wait_n = 5;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("t7_rst_ma_rdata", ma_rdata, 64'd0);
        chk("t7_rst_if_rdata", if_rdata, 64'd0);
        tick();
        rst_n = 1'b1; wait_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (mem_req && mem_addr == 64'h800) seen = 1'b1;
        end
        chk("t7_regrant", {63'd0, seen}, 64'd1);
        tick();
        ma_req = 1'b0;
        repeat (3) tick();
        chk("t7_final_ma_rdata", ma_rdata, rd_fn(64'h800));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data/address width.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive data grants while fetch waits.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  fetch read request, level, held until stall low.
REQ-006 if_addr  input  XLEN  fetch address, stable while if_req high.
REQ-007 if_rdata  output  XLEN  fetch read data, registered.
REQ-008 if_stall  output  1  fetch stall.
REQ-009 ma_req  input  1  memoryaccess request, level, held until stall low.
REQ-010 ma_we  input  3  bit2 write enable, bits1:0 access size.
REQ-011 ma_addr / ma_wdata  input  XLEN  data address / store data, stable while ma_req high.
REQ-012 ma_rdata  output  XLEN  load data, registered.
REQ-013 ma_stall  output  1  memoryaccess stall.
REQ-014 mem_req  output  1  shared-port request.
REQ-015 mem_we  output  3  shared-port write enable/size; 3'b000 for fetch.
REQ-016 mem_addr / mem_wdata  output  XLEN  shared-port address / write data.
REQ-017 mem_ready  input  1  shared-port completion, valid only while mem_req high.
REQ-018 mem_rdata  input  XLEN  shared-port read data, valid with mem_ready.

Function
REQ-019 FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-020 IDLE: grant D if ma_req and not starve; else I if if_req; else stay IDLE.
REQ-021 starve = if_req high and starve_cnt == STARVE_MAX; when starve, grant I even if ma_req high.
REQ-022 starve_cnt increments on every D grant while if_req high, saturates at STARVE_MAX, clears on every I grant and whenever if_req is low.
REQ-023 BUSY_x: mem_req=1; mem_addr/mem_we/mem_wdata combinationally muxed from the granted requester; leave on mem_ready to DONE_x.
REQ-024 On mem_ready in BUSY_I, if_rdata loads mem_rdata; in BUSY_D with ma_we[2]=0, ma_rdata loads mem_rdata; stores leave ma_rdata unchanged.
REQ-025 DONE_x lasts exactly one cycle, mem_req=0, then IDLE.
REQ-026 if_stall = if_req and state != DONE_I; ma_stall = ma_req and state != DONE_D.
REQ-027 Minimum latency: req at cycle 0, mem_ready at cycle 1 gives stall low at cycle 2; each extra wait cycle adds one.
REQ-028 Requester dropping req during BUSY_x: transaction still completes; the read data register is still updated.
REQ-029 Simultaneous if_req and ma_req in IDLE, no starve: D wins; I remains stalled.
REQ-030 mem_ready outside BUSY_x is ignored.
REQ-031 Back-to-back: a new grant is decided only in IDLE, giving at least one idle cycle between transactions.

Reset
REQ-032 Asynchronous reset: state IDLE, starve_cnt 0, if_rdata 0, ma_rdata 0.
REQ-033 During reset, mem_req is 0, and if_stall/ma_stall follow REQ-026 with state IDLE.
REQ-034 Reset mid-transaction abandons it; no data register is updated.

Structure
REQ-035 State encoding and the ma_we bit positions (write-enable bit, size field) are defined in the shared core constants include, not locally.
REQ-036 Single module; no sub-module required.

Verification
REQ-037 Single fetch: if_req=1, if_addr=0x100, mem_ready at cycle 1 with rdata 0x13 -> if_stall low at cycle 2, if_rdata=0x13.
REQ-038 Simultaneous requests: both req at cycle 0 -> mem_addr=ma_addr first; fetch served after DONE_D plus one IDLE cycle.
REQ-039 Starvation: ma_req held high continuously with if_req high, STARVE_MAX=4 -> after 4 data grants, 5th grant goes to fetch; starve_cnt returns to 0.
REQ-040 Store: ma_we=3'b111, ma_wdata=0xDEAD, 3 wait cycles -> mem_we=3'b111 for 4 cycles of BUSY_D, ma_rdata unchanged, ma_stall low one cycle later.
REQ-041 Reset mid-BUSY_D: rst_n low -> mem_req 0 immediately, state IDLE, ma_rdata 0; after release, a pending ma_req is re-granted.
REQ-042 Dropped request: if_req deasserted during BUSY_I -> mem_req held until mem_ready, then DONE_I, then IDLE, no hang.
